// File: rtl/image_scan_ctrl.sv
// image_scan_ctrl: start/done controlled row-major scan of an image ROM.
// Issues at most one ROM read per cycle under a two-credit rule, buffers the
// returned words in a 2-entry FIFO with their frame-marker tags, and presents
// them on a valid/ready pixel stream with SOF/EOL/EOF markers.
// Optional feature macro: SCAN_BINARIZE_EN (binarize pixels against THRESH at
// FIFO push; dark ink, i.e. words below THRESH, become all-ones).
module image_scan_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 15,
  parameter int START_ADDR = 0,
  parameter int IMG_W      = 160,
  parameter int IMG_H      = 120,
  parameter int THRESH     = 128
) (
  input  logic                  clka,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_dout,
  output logic [DATA_WIDTH-1:0] pix_data,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic                  pix_sof,
  output logic                  pix_eol,
  output logic                  pix_eof
);

  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [COL_W-1:0]      COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0]      ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ST  = ADDR_WIDTH'(START_ADDR);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_next;

  // Scan position of the next pixel to issue.
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;

  // Stage p1: read issued last cycle, ROM word arrives this cycle.
  logic       vld_p1;
  logic [2:0] tag_p1;   // {sof, eol, eof}

  // Output FIFO, two entries.
  logic [DATA_WIDTH-1:0] fifo_data [2];
  logic [2:0]            fifo_tag  [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            fifo_count;

  logic       pop;
  logic       push;
  logic       issue;
  logic       last_pix;
  logic [2:0] used;
  logic [2:0] issue_tag;
  logic [DATA_WIDTH-1:0] push_data;

  // Maps a raw ROM word to the streamed pixel value.
  function automatic logic [DATA_WIDTH-1:0] binarize(input logic [DATA_WIDTH-1:0] w);
    if (w < DATA_WIDTH'(THRESH)) begin
      return {DATA_WIDTH{1'b1}};
    end
    return '0;
  endfunction

`ifdef SCAN_BINARIZE_EN
  assign push_data = binarize(rom_dout);
`else
  assign push_data = rom_dout;
`endif

  // Handshake and credit accounting: outstanding reads plus buffered pixels
  // after this cycle's pop must stay below the FIFO depth.
  always_comb begin
    pix_valid = (fifo_count != 2'd0);
    pop       = pix_valid && pix_ready;
    push      = vld_p1;
    used      = {1'b0, fifo_count} + {2'b00, vld_p1} - {2'b00, pop};
    issue     = (state == RUN) && (used < 3'd2);
    last_pix  = (col == COL_LAST) && (row == ROW_LAST);
    issue_tag = {(col == '0) && (row == '0), (col == COL_LAST), last_pix};
  end

  // Next-state and status outputs; DONE is entered on the edge that empties
  // the pipeline so done follows the final transfer immediately.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (issue && last_pix) state_next = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (used == 3'd0) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clka) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Address and scan-position counters; parked at frame origin outside a scan.
  always_ff @(posedge clka) begin
    if (!rst_n) begin
      rom_addr <= ADDR_ST;
      col      <= '0;
      row      <= '0;
    end else if (issue) begin
      rom_addr <= rom_addr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
      if (col == COL_LAST) begin
        col <= '0;
        row <= last_pix ? '0 : row + {{(ROW_W-1){1'b0}}, 1'b1};
      end else begin
        col <= col + {{(COL_W-1){1'b0}}, 1'b1};
      end
    end else if ((state_next == DONE) || (state_next == IDLE)) begin
      rom_addr <= ADDR_ST;
      col      <= '0;
      row      <= '0;
    end
  end

  // ---- stage p0 -> p1: issued read becomes in-flight ----
  always_ff @(posedge clka) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= issue;
    end
  end

  // In-flight tags travel with the read.
  always_ff @(posedge clka) begin
    if (issue) tag_p1 <= issue_tag;
  end

  // ---- stage p1 -> FIFO: ROM word and tags captured ----
  always_ff @(posedge clka) begin
    if (push) begin
      fifo_data[wr_ptr] <= push_data;
      fifo_tag[wr_ptr]  <= tag_p1;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clka) begin
    if (!rst_n) begin
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_count <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Head-of-FIFO presentation; zeroed when nothing is valid.
  always_comb begin
    pix_data = '0;
    pix_sof  = 1'b0;
    pix_eol  = 1'b0;
    pix_eof  = 1'b0;
    if (pix_valid) begin
      pix_data = fifo_data[rd_ptr];
      pix_sof  = fifo_tag[rd_ptr][2];
      pix_eol  = fifo_tag[rd_ptr][1];
      pix_eof  = fifo_tag[rd_ptr][0];
    end
  end

endmodule

// File: tb/tb_image_scan_ctrl.sv
// Directed bench for image_scan_ctrl on a 4x3 frame with a behavioral ROM.
module tb_image_scan_ctrl;

  localparam int DW = 8;
  localparam int AW = 8;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int N  = W * H;

  logic          clka = 1'b0;
  logic          rst_n;
  logic          start;
  logic          busy;
  logic          done;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_dout;
  logic [DW-1:0] pix_data;
  logic          pix_valid;
  logic          pix_ready;
  logic          pix_sof;
  logic          pix_eol;
  logic          pix_eof;

  logic [DW-1:0] rom [0:255];

  int n_cmp = 0;
  int n_err = 0;

  image_scan_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .START_ADDR(0),
    .IMG_W(W), .IMG_H(H), .THRESH(128)
  ) dut (
    .clka(clka), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .rom_addr(rom_addr), .rom_dout(rom_dout), .pix_data(pix_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_sof(pix_sof),
    .pix_eol(pix_eol), .pix_eof(pix_eof)
  );

  always #5 clka = ~clka;

  // Synchronous-read ROM model: one cycle address-to-data.
  always @(posedge clka) rom_dout <= rom[rom_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_pix(input logic [DW-1:0] w);
`ifdef SCAN_BINARIZE_EN
    return (w < 8'd128) ? 8'hFF : 8'h00;
`else
    return w;
`endif
  endfunction

  task automatic step();
    @(posedge clka);
    #1;
  endtask

  // mode 0: ready held high; mode 1: ready 1,0,0,1 repeating;
  // mode 2: ready high with stray start pulses during RUN and DRAIN.
  // rst_after > 0 aborts the frame with reset once that many transfers happened.
  task automatic frame(input int mode, input int rst_after);
    int got = 0;
    int dones = 0;
    int done_cyc = -1;
    int first_vld = -1;
    bit rdy;
    start = 1'b1;
    pix_ready = 1'b0;
    for (int c = 1; c <= 120; c++) begin
      step();
      start = ((mode == 2) && (c == 5 || c == 13)) ? 1'b1 : 1'b0;
      if ((rst_after > 0) && (got == rst_after)) begin
        rst_n = 1'b0;
        pix_ready = 1'b0;
        step();
        chk("rst_valid", pix_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        rst_n = 1'b1;
        for (int j = 0; j < 20; j++) begin
          step();
          if (done) begin
            chk("rst_no_done", done, 1'b0);
          end
        end
        chk("rst_idle_valid", pix_valid, 1'b0);
        return;
      end
      case (mode)
        1:       rdy = (((c - 1) % 4) == 0) || (((c - 1) % 4) == 3);
        default: rdy = 1'b1;
      endcase
      pix_ready = rdy;
      if (pix_valid && first_vld < 0) first_vld = c;
      chk("addr_ahead", ((int'(rom_addr) - got) <= 2), 1'b1);
      if (pix_valid && rdy) begin
        chk("data", pix_data, exp_pix(rom[got]));
        chk("sof", pix_sof, (got == 0));
        chk("eol", pix_eol, ((got % W) == (W - 1)));
        chk("eof", pix_eof, (got == N - 1));
        got++;
      end
      if (done) begin
        dones++;
        if (done_cyc < 0) done_cyc = c;
        chk("busy_at_done", busy, 1'b0);
        chk("addr_at_done", rom_addr, 8'd0);
        chk("count_at_done", got, N);
      end
      if (done_cyc > 0 && c >= done_cyc + 4) break;
    end
    pix_ready = 1'b0;
    chk("pix_count", got, N);
    chk("done_count", dones, 1);
    chk("end_busy", busy, 1'b0);
    chk("end_valid", pix_valid, 1'b0);
    if (mode != 1) begin
      chk("first_valid_cyc", first_vld, 3);
      chk("done_cyc", done_cyc, N + 3);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'(i);
    rst_n = 1'b0;
    start = 1'b0;
    pix_ready = 1'b0;

    // Reset held two cycles, then idle without start.
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("idle_outputs",
          {busy, done, pix_valid, pix_sof, pix_eol, pix_eof, pix_data, rom_addr},
          22'd0);
    end

    // Full frame, ready high.
    frame(0, 0);
    // Same frame under backpressure.
    frame(1, 0);
    // Stray starts ignored, then a second identical frame.
    frame(2, 0);
    frame(0, 0);
    // Mid-scan reset after 5 transfers, then restart from pixel 0.
    frame(0, 5);
    frame(0, 0);

    // Threshold boundary words.
    rom[0] = 8'd0;
    rom[1] = 8'd127;
    rom[2] = 8'd128;
    rom[3] = 8'd255;
    frame(0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/image_scan_ctrl.md
# image_scan_ctrl

Sequencer that streams a stored image out of the `memoryConfig` block ROM in row-major order. It replaces the free-running address counter with a start/done controlled scan. The pixel stream carries valid/ready backpressure and frame markers (start of frame, end of line, end of frame). It sits between the image ROM and the downstream character-segmentation pipeline, and owns the ROM address bus exclusively.

## Interface
- `DATA_WIDTH`, 8, pixel/ROM word width
- `ADDR_WIDTH`, 15, ROM address width
- `START_ADDR`, 0, ROM address of pixel (row 0, col 0)
- `IMG_W`, 160, pixels per row (≥2)
- `IMG_H`, 120, rows per frame (≥1); `START_ADDR + IMG_W*IMG_H - 1` must be ≤ 2^ADDR_WIDTH-1
- `THRESH`, 128, binarization threshold (used only with `SCAN_BINARIZE_EN`)
- `clka` input 1: sole clock, all logic on rising edge
- `rst_n` input 1: reset, synchronous, active-low
- `start` input 1: begin a frame scan; sampled only in IDLE
- `busy` output 1: high in RUN and DRAIN
- `done` output 1: one-cycle pulse after the last pixel is accepted
- `rom_addr` output ADDR_WIDTH: to ROM `addra`
- `rom_dout` input DATA_WIDTH: from ROM `douta`; valid one cycle after the address is sampled
- `pix_data` output DATA_WIDTH: pixel value
- `pix_valid` output 1: `pix_data` and the frame markers are valid
- `pix_ready` input 1: downstream accepts; a transfer occurs when valid && ready
- `pix_sof` output 1: current pixel is (0,0)
- `pix_eol` output 1: current pixel is the last column
- `pix_eof` output 1: current pixel is the last pixel of the frame

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: `rom_addr`=START_ADDR, counters zero. `start`=1 → RUN.
- RUN: one ROM read is issued per cycle when `inflight + fifo_count - pop < 2`.
  - `pop` = a transfer occurs this cycle.
  - An issue advances `rom_addr` by 1 and the col/row counters (col wraps IMG_W-1→0, row increments).
  - The issue of the pixel (IMG_W-1, IMG_H-1) → DRAIN.
- `inflight` (0/1) marks a read issued last cycle. Its `rom_dout`, plus its row/col tags, is pushed into a 2-entry output FIFO the following cycle.
- DRAIN: no issues. When the FIFO is empty and `inflight`=0 → DONE.
- DONE: `done`=1 for exactly one cycle → IDLE. `rom_addr` returns to START_ADDR.
- `start` in RUN/DRAIN/DONE is ignored; it is not queued.
- Markers come from the tags stored with each FIFO entry, never from the live counters.
- FIFO never overflows; the credit rule guarantees this, and a push into a full FIFO is a design error.
- `pix_data` holds stable while `pix_valid`=1 and `pix_ready`=0.
- Reset mid-scan (`rst_n`=0 at any edge):
  - state → IDLE, FIFO flushed, `inflight` cleared.
  - No `done` is generated.

## Timing
- Reset values: `busy`=0, `done`=0, `pix_valid`=0, `pix_sof`/`pix_eol`/`pix_eof`=0, `pix_data`=0, `rom_addr`=START_ADDR.
- Start latency: for `start` sampled at edge k:
  - ROM latches START_ADDR at edge k+1.
  - The pixel is in the FIFO at edge k+2.
  - `pix_valid` is high in the cycle after edge k+2.
- Throughput: 1 pixel/cycle with `pix_ready` held high. A frame takes IMG_W*IMG_H+3 cycles from start to `done`.
- Backpressure: while `pix_ready`=0, at most 2 pixels are buffered and `rom_addr` holds. Resuming `pix_ready` gives a transfer in the same cycle, with no bubble.
- `done` is asserted the cycle after the edge at which the `pix_eof` pixel transferred. `busy` falls in that same cycle.

## Configuration
- `SCAN_BINARIZE_EN` defined:
  - `pix_data` = {DATA_WIDTH{1'b1}} when the ROM word < THRESH (dark ink), else 0.
  - The comparison is applied at FIFO push.
- `SCAN_BINARIZE_EN` undefined: `pix_data` is the raw ROM word, and THRESH is unused.

## Test plan
- Reset then idle: hold `rst_n`=0 2 cycles, release, no `start` → all outputs at reset values and `rom_addr`=START_ADDR for 20 cycles.
- Full frame, IMG_W=4, IMG_H=3, ROM[i]=i, `pix_ready`=1:
  - 12 pixels 0..11 on consecutive cycles.
  - `pix_sof` on 0, `pix_eol` on 3/7/11, `pix_eof` on 11.
  - `done` pulse at cycle 15 after start.
- Backpressure: same frame with `pix_ready` toggling 1,0,0,1,… → identical ordered data/marker sequence, no duplicates/drops, `rom_addr` never more than 2 ahead of the accepted count.
- Ignored start: pulse `start` during RUN and DRAIN → exactly one frame and one `done`. A new `start` after `done` → second identical frame.
- Mid-scan reset: `rst_n`=0 after 5 transfers → next cycle `pix_valid`=0 and `busy`=0, no `done`. A restart streams from pixel 0.
- `SCAN_BINARIZE_EN`, THRESH=128, ROM words 0,127,128,255 → `pix_data` FF,FF,00,00.
